// File: rtl/serial_tx_frontend_if.sv
// ---------------------------------------------------------------------------
// serial_tx_frontend_if
// Byte-push handshake between the GPU frame-dump output (master) and the
// serial transmit frontend (slave).
//   STX_DATA  [7:0]  byte to transmit, master -> slave
//   STX_SEND         one-cycle push strobe, master -> slave
//   STX_READY        slave can take a byte this cycle, slave -> master
// Handshake: a byte moves on a rising edge where STX_SEND=1 and STX_READY=1.
// STX_READY never depends on STX_SEND. A STX_SEND while STX_READY=0 is not
// retried by the slave: the byte is lost and the slave flags it.
// ---------------------------------------------------------------------------
interface serial_tx_frontend_if;
  logic [7:0] STX_DATA;
  logic       STX_SEND;
  logic       STX_READY;

  modport master (output STX_DATA, output STX_SEND, input STX_READY);
  modport slave  (input STX_DATA, input STX_SEND, output STX_READY);
endinterface

// File: rtl/serial_tx_frontend.sv
// ---------------------------------------------------------------------------
// serial_tx_frontend
// Accepts bytes from the GPU over the STX push handshake into a small FIFO
// and sends each one on an asynchronous 8N1 line (start, 8 data LSB first,
// stop), back to back when more bytes are waiting.
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous, active-high
//   stx          STX handshake, slave side (STX_DATA, STX_SEND, STX_READY)
//   TX           serial line, idle high, driven from a flop
//   BUSY         FIFO non-empty or a frame in progress
//   OVERRUN      sticky: a push arrived while the FIFO was full
//   dbg_state_o  current line FSM state (IDLE/START/DATA/STOP)
// ---------------------------------------------------------------------------
module serial_tx_frontend #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  serial_tx_frontend_if.slave  stx,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output logic [1:0]           dbg_state_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovr_q, ovr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic ready;
  logic push;
  logic pop;
  logic bit_end;

  // Ready comes only from the registered count, so a pop at the same edge
  // never makes room for a push into a full FIFO.
  assign ready   = (cnt_q < CNT_FULL);
  assign push    = stx.STX_SEND && ready;
  assign bit_end = (baud_q == BAUD_MAX);

  // Line FSM: next state, shifter, baud/bit counters and the TX level that
  // the TX flop takes at the coming edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // Next bit on the line is the one that shifts into position 0.
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (cnt_q != '0) begin
            // Back-to-back frame: no idle bit between stop and next start.
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping and sticky overrun flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q | (stx.STX_SEND & ~ready);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      ovr_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovr_q    <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= stx.STX_DATA;
  end

  assign stx.STX_READY = ready;
  assign TX            = tx_q;
  assign OVERRUN       = ovr_q;
  assign BUSY          = (state_q != S_IDLE) || (cnt_q != '0);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_serial_tx_frontend.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_frontend
// Two frontends share one clock: u_dut4 (CLKS_PER_BIT=4) and u_dut2
// (CLKS_PER_BIT=2), both FIFO_DEPTH=4. A frame-level model predicts TX,
// STX_READY, BUSY and OVERRUN for each and is compared on every falling
// edge; directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_serial_tx_frontend;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst4, rst2;
  always #5 clk = ~clk;

  serial_tx_frontend_if if4 ();
  serial_tx_frontend_if if2 ();

  logic       tx4, busy4, ovr4;
  logic       tx2, busy2, ovr2;
  logic [1:0] st4, st2;

  serial_tx_frontend #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
    .CLK(clk), .RESET(rst4), .stx(if4.slave),
    .TX(tx4), .BUSY(busy4), .OVERRUN(ovr4), .dbg_state_o(st4)
  );

  serial_tx_frontend #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .CLK(clk), .RESET(rst2), .stx(if2.slave),
    .TX(tx2), .BUSY(busy2), .OVERRUN(ovr2), .dbg_state_o(st2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // A frame is 10 levels (start, d0..d7, stop), each cpb cycles long.
  // m_pos counts cycles into the current frame.
  int         m_act [2];
  int         m_pos [2];
  int         m_n   [2];
  bit         m_ovr [2];
  bit         m_valid [2];
  logic [7:0] m_cur [2];
  logic [7:0] m_q   [2][DEPTH];

  function automatic logic frame_level(input logic [7:0] b, input int idx);
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else               return 1'b1;
  endfunction

  task automatic m_pop(input int k);
    m_cur[k] = m_q[k][0];
    for (int i = 0; i < DEPTH-1; i++) m_q[k][i] = m_q[k][i+1];
    m_n[k]--;
  endtask

  task automatic model_step(input int k, input int cpb, input logic rst,
                            input logic send, input logic [7:0] d);
    bit rdy;
    if (rst) begin
      m_act[k] = 0; m_pos[k] = 0; m_n[k] = 0; m_ovr[k] = 0; m_valid[k] = 1;
    end else begin
      rdy = (m_n[k] < DEPTH);
      if (m_act[k] == 0) begin
        if (m_n[k] > 0) begin m_pop(k); m_act[k] = 1; m_pos[k] = 0; end
      end else if (m_pos[k] == 10*cpb - 1) begin
        if (m_n[k] > 0) begin m_pop(k); m_pos[k] = 0; end
        else m_act[k] = 0;
      end else begin
        m_pos[k]++;
      end
      if (send) begin
        if (rdy) begin m_q[k][m_n[k]] = d; m_n[k]++; end
        else m_ovr[k] = 1;
      end
    end
  endtask

  function automatic logic exp_tx(input int k, input int cpb);
    if (m_act[k] != 0) return frame_level(m_cur[k], m_pos[k] / cpb);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    model_step(0, 4, rst4, if4.STX_SEND, if4.STX_DATA);
    model_step(1, 2, rst2, if2.STX_SEND, if2.STX_DATA);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid[0]) begin
      chk("m4_tx",   tx4,           exp_tx(0, 4));
      chk("m4_rdy",  if4.STX_READY, m_n[0] < DEPTH);
      chk("m4_busy", busy4,         (m_act[0] != 0) || (m_n[0] != 0));
      chk("m4_ovr",  ovr4,          m_ovr[0]);
    end
    if (m_valid[1]) begin
      chk("m2_tx",   tx2,           exp_tx(1, 2));
      chk("m2_rdy",  if2.STX_READY, m_n[1] < DEPTH);
      chk("m2_busy", busy2,         (m_act[1] != 0) || (m_n[1] != 0));
      chk("m2_ovr",  ovr2,          m_ovr[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input logic s, input logic [7:0] d);
    if (k == 0) begin if4.STX_SEND = s; if4.STX_DATA = d; end
    else        begin if2.STX_SEND = s; if2.STX_DATA = d; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push one byte: sampled at the next edge E; returns 1 time unit after E.
  task automatic push(input int k, input logic [7:0] d);
    drive(k, 1'b1, d);
    @(posedge clk); #1;
    drive(k, 1'b0, 8'h00);
  endtask

  task automatic reset4(input int n);
    rst4 = 1'b1;
    idle(n);
    rst4 = 1'b0;
  endtask

  // Count falling-edge samples with BUSY=1 until BUSY drops (bounded).
  task automatic measure_busy(input int k, input int exp, input string name);
    int  n;
    bit  done;
    logic b;
    n = 0; done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      b = (k == 0) ? busy4 : busy2;
      if (b) n++;
      else done = 1;
    end
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk(name, n, exp);
  endtask

  logic [9:0] a5_lv;
  logic [5:0] six_rdy;
  logic [7:0] d2 [4];

  // ---------------- stimulus ----------------
  initial begin
    rst4 = 1'b1; rst2 = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset values, during and after reset.
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx4, 1'b1);
      chk("rst_rdy", if4.STX_READY, 1'b1);
      chk("rst_busy", busy4, 1'b0);
      chk("rst_ovr", ovr4, 1'b0);
    end
    @(posedge clk); #1;
    rst4 = 1'b0; rst2 = 1'b0;
    idle(5);
    chk("post_rst_tx", tx4, 1'b1);
    chk("post_rst_busy", busy4, 1'b0);
    chk("post_rst_rdy", if4.STX_READY, 1'b1);
    chk("post_rst_ovr", ovr4, 1'b0);

    // Single byte 0xA5: levels 0,1,0,1,0,0,1,0,1,1 (bit i = level i).
    a5_lv = 10'b1101001010;
    push(0, 8'hA5);
    @(negedge clk);
    chk("a5_busy_E", busy4, 1'b1);
    chk("a5_tx_E", tx4, 1'b1);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      chk("a5_tx", tx4, a5_lv[j/4]);
    end
    chk("a5_busy_last", busy4, 1'b1);
    @(negedge clk);
    chk("a5_busy_end", busy4, 1'b0);
    chk("a5_tx_end", tx4, 1'b1);
    idle(3);

    // Six consecutive pushes into DEPTH=4: sixth is dropped.
    six_rdy = 6'b001111;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, 8'(i + 1));
      @(posedge clk); #1;
      chk("six_rdy", if4.STX_READY, six_rdy[i]);
    end
    drive(0, 1'b0, 8'h00);
    chk("six_ovr", ovr4, 1'b1);
    measure_busy(0, 196, "six_busy_len");
    idle(3);
    reset4(2);
    idle(2);

    // Full FIFO, push attempted on the stop->start pop edge.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 8'h10 + 8'(i));
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 8'h00);
    idle(36);
    chk("full_rdy_before", if4.STX_READY, 1'b0);
    chk("full_ovr_before", ovr4, 1'b0);
    push(0, 8'h99);
    chk("full_rdy_after", if4.STX_READY, 1'b1);
    chk("full_ovr_after", ovr4, 1'b1);
    measure_busy(0, 160, "full_busy_len");
    idle(3);
    reset4(2);
    idle(2);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    push(0, 8'h3C);
    push(0, 8'hAA);
    push(0, 8'hBB);
    idle(15);
    chk("mid_tx_bit3", tx4, 1'b1);
    chk("mid_busy", busy4, 1'b1);
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("mid_rst_tx", tx4, 1'b1);
    chk("mid_rst_busy", busy4, 1'b0);
    chk("mid_rst_rdy", if4.STX_READY, 1'b1);
    idle(40);
    chk("mid_quiet_busy", busy4, 1'b0);
    push(0, 8'h55);
    measure_busy(0, 41, "mid_55_len");
    idle(3);

    // CLKS_PER_BIT=2: single pushes every 25 cycles, 20-cycle frames.
    d2[0] = 8'h00; d2[1] = 8'hFF; d2[2] = 8'h81; d2[3] = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      push(1, d2[i]);
      measure_busy(1, 21, "c2_busy_len");
      chk("c2_tx_idle", tx2, 1'b1);
      idle(3);
    end
    chk("c2_ovr", ovr2, 1'b0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
